r2r_dac_player: RTL and testbench

- Transmit-direction counterpart of the R2R ADC path: the ladder is used as an 8-bit DAC output instead of a measurement reference.
- Accepts sample codes over a valid/ready stream into an internal FIFO.
- Emits one code per sample tick on R2R_output at a fixed rate set by a clock divider.
- Sits between a waveform/sample source (e.g. a table reader or host path) and the external R2R ladder pins.

---
 rtl/r2r_dac_player.sv | 145 ++++++++++++++
 tb/tb_r2r_dac_player.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/r2r_dac_player.sv
// R2R ladder sample player: FIFO-buffered codes emitted one per CLK_DIV-cycle tick.
// Latency: tick cycle T -> new code + strobe in T+1; in_ready drops when the FIFO is full.

module r2r_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty   = (wptr == rptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rptr[AW-1:0]];
    assign level   = wptr - rptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rptr <= rptr + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr[AW-1:0]] <= push_data;
        end
    end
endmodule

module r2r_dac_player #(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 16,
    parameter int               CLK_DIV   = 100_000,
    parameter logic [WIDTH-1:0] IDLE_CODE = 8'h80
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   clear_underrun,
    output logic [WIDTH-1:0]       R2R_output,
    output logic                   sample_strobe,
    output logic                   underrun,
    output logic [$clog2(DEPTH):0] level
);
    localparam int              CW    = $clog2(CLK_DIV);
    localparam int              LW    = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]   LAST  = CW'(CLK_DIV - 1);

    logic [CW-1:0]    tick_cnt;
    logic             tick;
    logic             pop;
    logic             push;
    logic             fifo_full;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_head;

    assign tick     = enable && (tick_cnt == LAST);
    assign pop      = tick && !fifo_empty;
    assign in_ready = !reset && !fifo_full;
    assign push     = in_valid && in_ready;

    // Dropping enable discards the partial period so a re-enable always waits a full CLK_DIV.
    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            tick_cnt <= '0;
        end else if (tick_cnt == LAST) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + CW'(1);
        end
    end

    r2r_sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (in_data),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (level)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            R2R_output    <= IDLE_CODE;
            sample_strobe <= 1'b0;
        end else begin
            sample_strobe <= pop;
            if (pop) begin
                R2R_output <= fifo_head;
            end
        end
    end

    // A fresh underrun outranks a coincident clear so the event is never lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            underrun <= 1'b0;
        end else if (tick && fifo_empty) begin
            underrun <= 1'b1;
        end else if (clear_underrun) begin
            underrun <= 1'b0;
        end
    end

    a_level_bound: assert property (@(posedge clk) disable iff (reset)
        level <= LW'(DEPTH));
    a_strobe_after_tick: assert property (@(posedge clk) disable iff (reset)
        sample_strobe |-> $past(tick));
    a_output_moves_on_strobe: assert property (@(posedge clk) disable iff (reset)
        !$stable(R2R_output) |-> (sample_strobe || $past(reset)));
endmodule

// File: tb/tb_r2r_dac_player.sv
// Bench for r2r_dac_player (DEPTH=4, CLK_DIV=4) against a queue-based behavioural model.
module tb_r2r_dac_player;
    localparam int DEPTH   = 4;
    localparam int CLK_DIV = 4;
    localparam logic [7:0] IDLE = 8'h80;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       clear_underrun = 1'b0;
    logic       in_ready;
    logic [7:0] R2R_output;
    logic       sample_strobe;
    logic       underrun;
    logic [2:0] level;

    int tests = 0;
    int fails = 0;

    // Behavioural model state
    logic [7:0] q[$];
    int         phase = 0;
    logic [7:0] m_out = IDLE;
    logic       m_strobe = 1'b0;
    logic       m_und = 1'b0;

    r2r_dac_player #(
        .WIDTH     (8),
        .DEPTH     (DEPTH),
        .CLK_DIV   (CLK_DIV),
        .IDLE_CODE (IDLE)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .clear_underrun (clear_underrun),
        .R2R_output     (R2R_output),
        .sample_strobe  (sample_strobe),
        .underrun       (underrun),
        .level          (level)
    );

    always #5 clk = ~clk;

    // Advance one clock and update the model from the inputs presented during that cycle.
    task automatic cycle();
        logic ready_now, tick_now, empty_now;
        ready_now = !reset && (q.size() < DEPTH);
        tick_now  = enable && (phase == CLK_DIV - 1);
        empty_now = (q.size() == 0);
        @(posedge clk);
        if (reset) begin
            q.delete();
            phase    = 0;
            m_out    = IDLE;
            m_strobe = 1'b0;
            m_und    = 1'b0;
        end else begin
            m_strobe = 1'b0;
            if (tick_now && !empty_now) begin
                m_out    = q.pop_front();
                m_strobe = 1'b1;
            end
            if (tick_now && empty_now) m_und = 1'b1;
            else if (clear_underrun)   m_und = 1'b0;
            if (in_valid && ready_now) q.push_back(in_data);
            phase = enable ? (phase + 1) % CLK_DIV : 0;
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; enable = 1'b0; in_valid = 1'b0; clear_underrun = 1'b0;
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; in_valid = 1'b0;
        cycle();
        cycle();
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        tests++; if (R2R_output !== IDLE) begin fails++; $display("FAIL reset_output: got %h expected %h", R2R_output, IDLE); end
        tests++; if (sample_strobe !== 1'b0) begin fails++; $display("FAIL reset_strobe: got %b expected 0", sample_strobe); end
        tests++; if (underrun !== 1'b0) begin fails++; $display("FAIL reset_underrun: got %b expected 0", underrun); end
        tests++; if (level !== 3'd0) begin fails++; $display("FAIL reset_level: got %0d expected 0", level); end
        reset = 1'b0;
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL post_reset_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_idle_underrun();
        enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            tests++; if (sample_strobe !== 1'b0) begin fails++; $display("FAIL idle_strobe: got %b expected 0", sample_strobe); end
        end
        tests++; if (underrun !== 1'b0) begin fails++; $display("FAIL idle_underrun_early: got %b expected 0", underrun); end
        cycle();
        tests++; if (underrun !== 1'b1) begin fails++; $display("FAIL idle_underrun_tick: got %b expected 1", underrun); end
        tests++; if (sample_strobe !== 1'b0) begin fails++; $display("FAIL idle_tick_strobe: got %b expected 0", sample_strobe); end
        tests++; if (R2R_output !== IDLE) begin fails++; $display("FAIL idle_output: got %h expected %h", R2R_output, IDLE); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] got[$];
        int         when[$];
        logic [7:0] words [3];
        words[0] = 8'h10; words[1] = 8'h20; words[2] = 8'h30;
        do_reset();
        enable = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = words[i];
            cycle();
        end
        in_valid = 1'b0;
        tests++; if (level !== 3'd3) begin fails++; $display("FAIL b2b_level_loaded: got %0d expected 3", level); end
        for (int i = 0; i < 14; i++) begin
            cycle();
            tests++;
            if (R2R_output !== m_out || sample_strobe !== m_strobe || int'(level) !== q.size() || underrun !== m_und) begin
                fails++;
                $display("FAIL b2b_cycle%0d: got out=%h stb=%b lvl=%0d und=%b expected out=%h stb=%b lvl=%0d und=%b",
                         i, R2R_output, sample_strobe, level, underrun, m_out, m_strobe, q.size(), m_und);
            end
            if (sample_strobe) begin got.push_back(R2R_output); when.push_back(i); end
        end
        tests++; if (got.size() !== 3) begin fails++; $display("FAIL b2b_strobe_count: got %0d expected 3", got.size()); end
        for (int i = 0; i < 3 && i < got.size(); i++) begin
            tests++; if (got[i] !== words[i]) begin fails++; $display("FAIL b2b_order%0d: got %h expected %h", i, got[i], words[i]); end
        end
        for (int i = 1; i < when.size(); i++) begin
            tests++; if (when[i] - when[i-1] !== CLK_DIV) begin fails++; $display("FAIL b2b_spacing: got %0d expected %0d", when[i] - when[i-1], CLK_DIV); end
        end
        tests++; if (R2R_output !== 8'h30 || underrun !== 1'b1) begin fails++; $display("FAIL b2b_final: got out=%h und=%b expected out=30 und=1", R2R_output, underrun); end
    endtask

    task automatic test_full_backpressure();
        logic [7:0] w [5];
        logic [7:0] got[$];
        for (int i = 0; i < 5; i++) w[i] = 8'($urandom);
        do_reset();
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = w[i];
            cycle();
        end
        in_data = w[4];
        tests++; if (level !== 3'd4) begin fails++; $display("FAIL full_level: got %0d expected 4", level); end
        for (int i = 0; i < 2; i++) begin
            tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL full_ready_hold: got %b expected 0", in_ready); end
            cycle();
        end
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL full_ready_pretick%0d: got %b expected 0", i, in_ready); end
            cycle();
        end
        tests++; if (in_ready !== 1'b1 || level !== 3'd3 || R2R_output !== w[0]) begin
            fails++; $display("FAIL full_after_tick: got rdy=%b lvl=%0d out=%h expected rdy=1 lvl=3 out=%h", in_ready, level, R2R_output, w[0]);
        end
        cycle();
        in_valid = 1'b0;
        tests++; if (level !== 3'd4) begin fails++; $display("FAIL full_fifth_accepted: got %0d expected 4", level); end
        for (int i = 0; i < 18; i++) begin
            cycle();
            if (sample_strobe) got.push_back(R2R_output);
        end
        tests++; if (got.size() !== 4) begin fails++; $display("FAIL full_drain_count: got %0d expected 4", got.size()); end
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            tests++; if (got[i] !== w[i+1]) begin fails++; $display("FAIL full_drain_order%0d: got %h expected %h", i, got[i], w[i+1]); end
        end
    endtask

    task automatic test_push_on_tick();
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        in_valid = 1'b1; in_data = 8'h55;
        cycle();
        in_valid = 1'b0;
        tests++; if (underrun !== 1'b1 || sample_strobe !== 1'b0 || level !== 3'd1) begin
            fails++; $display("FAIL pot_tick: got und=%b stb=%b lvl=%0d expected und=1 stb=0 lvl=1", underrun, sample_strobe, level);
        end
        for (int i = 0; i < 3; i++) begin
            cycle();
            tests++; if (sample_strobe !== 1'b0) begin fails++; $display("FAIL pot_gap_strobe: got %b expected 0", sample_strobe); end
        end
        cycle();
        tests++; if (sample_strobe !== 1'b1 || R2R_output !== 8'h55 || level !== 3'd0) begin
            fails++; $display("FAIL pot_next_tick: got stb=%b out=%h lvl=%0d expected stb=1 out=55 lvl=0", sample_strobe, R2R_output, level);
        end
    endtask

    // Runs straight after test_push_on_tick: FIFO empty, underrun set, counter at phase 0.
    task automatic test_clear_underrun();
        clear_underrun = 1'b1;
        cycle();
        clear_underrun = 1'b0;
        tests++; if (underrun !== 1'b0) begin fails++; $display("FAIL clr_isolated1: got %b expected 0", underrun); end
        cycle();
        cycle();
        clear_underrun = 1'b1;
        cycle();
        clear_underrun = 1'b0;
        tests++; if (underrun !== 1'b1) begin fails++; $display("FAIL clr_vs_set: got %b expected 1", underrun); end
        cycle();
        clear_underrun = 1'b1;
        cycle();
        clear_underrun = 1'b0;
        tests++; if (underrun !== 1'b0) begin fails++; $display("FAIL clr_isolated2: got %b expected 0", underrun); end
    endtask

    task automatic test_midstream_reset();
        bit saw_strobe;
        do_reset();
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 8'h10 * (i + 1);
            cycle();
        end
        enable = 1'b1; in_data = 8'h50;
        for (int i = 0; i < 5; i++) cycle();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        tests++; if (R2R_output !== 8'h20 || level !== 3'd3) begin
            fails++; $display("FAIL mid_setup: got out=%h lvl=%0d expected out=20 lvl=3", R2R_output, level);
        end
        reset = 1'b1;
        #1;
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL mid_ready_in_reset: got %b expected 0", in_ready); end
        cycle();
        tests++; if (R2R_output !== IDLE || level !== 3'd0 || underrun !== 1'b0 || sample_strobe !== 1'b0) begin
            fails++; $display("FAIL mid_reset_state: got out=%h lvl=%0d und=%b stb=%b expected out=80 lvl=0 und=0 stb=0",
                              R2R_output, level, underrun, sample_strobe);
        end
        reset = 1'b0;
        saw_strobe = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (sample_strobe) saw_strobe = 1'b1;
        end
        tests++; if (saw_strobe !== 1'b0 || R2R_output !== IDLE || underrun !== 1'b1) begin
            fails++; $display("FAIL mid_no_stale: got stb_seen=%b out=%h und=%b expected stb_seen=0 out=80 und=1", saw_strobe, R2R_output, underrun);
        end
    endtask

    task automatic test_random();
        int vprob;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            vprob          = (i < 300) ? 60 : 20;
            reset          = ($urandom_range(0, 127) == 0);
            enable         = ($urandom_range(0, 7) != 0);
            in_valid       = ($urandom_range(0, 99) < vprob);
            in_data        = 8'($urandom);
            clear_underrun = ($urandom_range(0, 15) == 0);
            #1;
            tests++;
            if (in_ready !== (!reset && q.size() < DEPTH)) begin
                fails++; $display("FAIL rand_ready%0d: got %b expected %b", i, in_ready, !reset && q.size() < DEPTH);
            end
            cycle();
            tests++;
            if (R2R_output !== m_out || sample_strobe !== m_strobe || int'(level) !== q.size() || underrun !== m_und) begin
                fails++;
                $display("FAIL rand_cycle%0d: got out=%h stb=%b lvl=%0d und=%b expected out=%h stb=%b lvl=%0d und=%b",
                         i, R2R_output, sample_strobe, level, underrun, m_out, m_strobe, q.size(), m_und);
            end
        end
        reset = 1'b0; in_valid = 1'b0; clear_underrun = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_idle_underrun();
        test_back_to_back();
        test_full_backpressure();
        test_push_on_tick();
        test_clear_underrun();
        test_midstream_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
